// File: rtl/video_timing_gen.sv
// Free-running progressive raster generator with a registered background pattern and frame reporting.
// Define VIDEO_COLORBAR_EN to build the 8-bar test pattern; otherwise the active region is flat BG_COLOR.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter logic        HS_POL   = 1'b1,
    parameter logic        VS_POL   = 1'b1,
    parameter logic [23:0] BG_COLOR = 24'h000040
) (
    input  logic        pclk,
    input  logic        rst,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_de,
    output logic [23:0] o_data,
    output logic        o_frame_start,
    output logic [15:0] o_frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_ACT_C  = 12'(H_ACTIVE);
    localparam logic [11:0] HS_BEG_C = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END_C = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST_C = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_ACT_C  = 12'(V_ACTIVE);
    localparam logic [11:0] VS_BEG_C = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END_C = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST_C = 12'(V_TOTAL - 1);

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic        h_wrap;
    logic        v_wrap;
    logic        frame_wrap;
    logic [15:0] frame_cnt_q;

    assign h_wrap     = (h_cnt == H_LAST_C);
    assign v_wrap     = (v_cnt == V_LAST_C);
    assign frame_wrap = h_wrap && v_wrap;

    // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge pclk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? 12'd0 : v_cnt + 12'd1;
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    // Bumps on the wrap edge; the registered copy then lines up with the next frame_start pulse.
    always_ff @(posedge pclk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (frame_wrap) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

`ifdef VIDEO_COLORBAR_EN
    localparam int unsigned BAR_W    = H_ACTIVE / 8;
    localparam int unsigned BAR_PW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BAR_PW-1:0] BAR_LAST = BAR_PW'(BAR_W - 1);

    logic [BAR_PW-1:0] bar_pix;
    logic [2:0]        bar_idx;

    // Tracks the bar under the current h_cnt without a divider; both sit at 0 whenever h_cnt is 0.
    always_ff @(posedge pclk) begin
        if (rst || h_wrap) begin
            bar_pix <= '0;
            bar_idx <= '0;
        end else if (h_cnt < H_ACT_C) begin
            if (bar_pix == BAR_LAST) begin
                bar_pix <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_pix <= bar_pix + 1'b1;
            end
        end
    end

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFFFF00;
            3'd2:    return 24'h00FFFF;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'hFF00FF;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    logic [23:0] pix_rgb;
    assign pix_rgb = bar_color(bar_idx);
`else
    logic [23:0] pix_rgb;
    assign pix_rgb = BG_COLOR;
`endif

    logic de_d;
    logic hs_d;
    logic vs_d;
    logic fs_d;

    always_comb begin
        de_d = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        hs_d = (h_cnt >= HS_BEG_C) && (h_cnt < HS_END_C);
        vs_d = (v_cnt >= VS_BEG_C) && (v_cnt < VS_END_C);
        fs_d = (h_cnt == 12'd0) && (v_cnt == 12'd0);
    end

    // Every output is registered from the same counter state so the downstream stage sees them aligned.
    always_ff @(posedge pclk) begin
        if (rst) begin
            o_hs          <= ~HS_POL;
            o_vs          <= ~VS_POL;
            o_de          <= 1'b0;
            o_data        <= '0;
            o_frame_start <= 1'b0;
            o_frame_cnt   <= '0;
        end else begin
            o_hs          <= hs_d ? HS_POL : ~HS_POL;
            o_vs          <= vs_d ? VS_POL : ~VS_POL;
            o_de          <= de_d;
            o_data        <= de_d ? pix_rgb : 24'h000000;
            o_frame_start <= fs_d;
            o_frame_cnt   <= frame_cnt_q;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a small 24x8 raster; expected outputs are derived from
// the cycle count since reset release, pushed when each edge is driven and compared after it.
module tb_video_timing_gen;

    localparam int HA = 16, HF = 2, HSW = 3, HB = 3;
    localparam int VA = 4,  VF = 1, VSW = 2, VB = 1;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FRAME = HT * VT;
    localparam logic HS_POL = 1'b1;
    localparam logic VS_POL = 1'b0;
    localparam logic [23:0] BG = 24'h123456;

    typedef struct {
        logic        rst;
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] data;
        logic        fs;
        logic [15:0] fcnt;
    } exp_t;

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic        o_hs;
    logic        o_vs;
    logic        o_de;
    logic [23:0] o_data;
    logic        o_frame_start;
    logic [15:0] o_frame_cnt;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    int   mcyc = 0;
    int   fbase = 0;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .BG_COLOR(BG)
    ) dut (
        .pclk(pclk),
        .rst(rst),
        .o_hs(o_hs),
        .o_vs(o_vs),
        .o_de(o_de),
        .o_data(o_data),
        .o_frame_start(o_frame_start),
        .o_frame_cnt(o_frame_cnt)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic exp_t model_out(input logic r, input int cyc, input int base);
        exp_t e;
        int pos, h, v;
        pos = cyc % FRAME;
        h = pos % HT;
        v = pos / HT;
        e.rst = r;
        if (r) begin
            e.hs = ~HS_POL; e.vs = ~VS_POL; e.de = 1'b0;
            e.data = '0; e.fs = 1'b0; e.fcnt = '0;
        end else begin
            e.de = (h < HA) && (v < VA);
            e.hs = (h >= HA + HF && h < HA + HF + HSW) ? HS_POL : ~HS_POL;
            e.vs = (v >= VA + VF && v < VA + VF + VSW) ? VS_POL : ~VS_POL;
`ifdef VIDEO_COLORBAR_EN
            e.data = e.de ? bars[h / (HA / 8)] : 24'h0;
`else
            e.data = e.de ? BG : 24'h0;
`endif
            e.fs = (pos == 0);
            e.fcnt = 16'((base + cyc / FRAME) & 16'hFFFF);
        end
        return e;
    endfunction

    // Drive one edge: set rst, optionally preload the frame counter, and log what that edge must produce.
    task automatic cycle(input logic r, input logic preload);
        @(negedge pclk);
        rst = r;
        if (preload) begin
            force dut.frame_cnt_q = 16'hFFFF;
            fbase = 16'hFFFF - mcyc / FRAME;
        end
        exp_q.push_back(model_out(r, mcyc, fbase));
        @(posedge pclk);
        if (r) begin
            mcyc = 0;
            fbase = 0;
        end else begin
            mcyc++;
        end
        if (preload) begin
            #1;
            release dut.frame_cnt_q;
        end
    endtask

    // Monitor: compare every logged edge, and measure frame_start spacing independently.
    initial begin
        exp_t e;
        int   since = 0;
        bit   from_reset = 1'b1;
        forever begin
            @(posedge pclk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("hs", 32'(o_hs), 32'(e.hs));
                check("vs", 32'(o_vs), 32'(e.vs));
                check("de", 32'(o_de), 32'(e.de));
                check("data", 32'(o_data), 32'(e.data));
                check("frame_start", 32'(o_frame_start), 32'(e.fs));
                check("frame_cnt", 32'(o_frame_cnt), 32'(e.fcnt));
                if (e.rst) begin
                    since = 0;
                    from_reset = 1'b1;
                end else begin
                    since++;
                    if (o_frame_start === 1'b1) begin
                        check("frame_gap", 32'(since), from_reset ? 32'd1 : 32'(FRAME));
                        since = 0;
                        from_reset = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        // Reset held for a few edges, then three full frames and a bit.
        repeat (3) cycle(1'b1, 1'b0);
        repeat (3 * FRAME + 10) cycle(1'b0, 1'b0);

        // Mid-frame reset at (h=10, v=2), then run past the next frame boundary.
        while ((mcyc % FRAME) != 2 * HT + 10) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        repeat (FRAME + 20) cycle(1'b0, 1'b0);

        // Preload the frame counter mid-frame to exercise the 16-bit wrap.
        while ((mcyc % FRAME) != 3 * HT + 5) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        repeat (FRAME + 20) cycle(1'b0, 1'b0);

        @(posedge pclk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
